// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I main control FSM:
// state encoding, opcode constants, datapath select codes and the control word.
package multicycle_ctrl_pkg;

    // Controller states (3-bit encoding).
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // RV32I major opcodes, IR[6:2].
    localparam logic [4:0] OPCODE_LOAD   = 5'b00000;
    localparam logic [4:0] OPCODE_FENCE  = 5'b00011;
    localparam logic [4:0] OPCODE_OP_IMM = 5'b00100;
    localparam logic [4:0] OPCODE_AUIPC  = 5'b00101;
    localparam logic [4:0] OPCODE_STORE  = 5'b01000;
    localparam logic [4:0] OPCODE_OP     = 5'b01100;
    localparam logic [4:0] OPCODE_LUI    = 5'b01101;
    localparam logic [4:0] OPCODE_BRANCH = 5'b11000;
    localparam logic [4:0] OPCODE_JALR   = 5'b11001;
    localparam logic [4:0] OPCODE_JAL    = 5'b11011;
    localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;

    // ALU operation class handed to the ALU control decoder.
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
    localparam logic [1:0] ALU_OP_ITYPE = 2'b11;

    // Next-PC source.
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JALR   = 2'b10;

    // ALU operand A source.
    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;

    // ALU operand B source.
    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    // Register-file write-back source.
    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;
    localparam logic [1:0] WB_IMM    = 2'b11;

    // Every enable and select the controller drives into the datapath.
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       retire;
    } ctrl_t;

    // True for every opcode this core implements (SYSTEM included).
    function automatic logic is_known_opcode(input logic [4:0] op);
        case (op)
            OPCODE_LOAD, OPCODE_FENCE, OPCODE_OP_IMM, OPCODE_AUIPC,
            OPCODE_STORE, OPCODE_OP, OPCODE_LUI, OPCODE_BRANCH,
            OPCODE_JALR, OPCODE_JAL, OPCODE_SYSTEM: is_known_opcode = 1'b1;
            default:                                 is_known_opcode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Purely combinational control decode: maps the current state, the IR opcode,
// the branch result and the memory handshake to the control word, the next
// state and the illegal-opcode flag set request.
module multicycle_ctrl_decode
    import multicycle_ctrl_pkg::*;
#(
    parameter bit HALT_ON_SYSTEM = 1'b1
) (
    input  state_t     i_state,
    input  logic [4:0] i_opcode,
    input  logic       i_br_taken,
    input  logic       i_mem_ready,
    output ctrl_t      o_ctrl,
    output state_t     o_next_state,
    output logic       o_set_illegal
);

    // Control word and next-state selection for every state/opcode pair.
    always_comb begin
        o_ctrl        = '0;
        o_next_state  = i_state;
        o_set_illegal = 1'b0;

        case (i_state)
            ST_FETCH: begin
                // ALU computes PC+4 while the instruction word is read.
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_a = SRC_A_PC;
                o_ctrl.alu_src_b = SRC_B_FOUR;
                o_ctrl.alu_op    = ALU_OP_ADD;
                if (i_mem_ready) begin
                    o_ctrl.ir_write = 1'b1;
                    o_ctrl.pc_write = 1'b1;
                    o_ctrl.pc_src   = PC_SRC_ALU;
                    o_next_state    = ST_DECODE;
                end
            end

            ST_DECODE: begin
                // Speculatively form OLD_PC+IMM into ALUOUT for branch/JAL/AUIPC.
                o_ctrl.alu_src_a = SRC_A_OLD_PC;
                o_ctrl.alu_src_b = SRC_B_IMM;
                o_ctrl.alu_op    = ALU_OP_ADD;
                if (i_opcode == OPCODE_FENCE) begin
                    o_ctrl.retire = 1'b1;
                    o_next_state  = ST_FETCH;
                end else if (i_opcode == OPCODE_SYSTEM) begin
                    if (HALT_ON_SYSTEM) begin
                        o_next_state = ST_HALT;
                    end else begin
                        o_ctrl.retire = 1'b1;
                        o_next_state  = ST_FETCH;
                    end
                end else if (!is_known_opcode(i_opcode)) begin
                    o_set_illegal = 1'b1;
                    o_next_state  = ST_HALT;
                end else begin
                    o_next_state = ST_EXEC;
                end
            end

            ST_EXEC: begin
                o_next_state = ST_FETCH;
                case (i_opcode)
                    OPCODE_OP: begin
                        o_ctrl.alu_src_a = SRC_A_RS1;
                        o_ctrl.alu_src_b = SRC_B_RS2;
                        o_ctrl.alu_op    = ALU_OP_RTYPE;
                        o_next_state     = ST_WB;
                    end
                    OPCODE_OP_IMM: begin
                        o_ctrl.alu_src_a = SRC_A_RS1;
                        o_ctrl.alu_src_b = SRC_B_IMM;
                        o_ctrl.alu_op    = ALU_OP_ITYPE;
                        o_next_state     = ST_WB;
                    end
                    OPCODE_LOAD, OPCODE_STORE: begin
                        // Effective address RS1+IMM lands in ALUOUT for MEM.
                        o_ctrl.alu_src_a = SRC_A_RS1;
                        o_ctrl.alu_src_b = SRC_B_IMM;
                        o_ctrl.alu_op    = ALU_OP_ADD;
                        o_next_state     = ST_MEM;
                    end
                    OPCODE_BRANCH: begin
                        // Target was formed in DECODE; the comparator decides.
                        o_ctrl.alu_src_a = SRC_A_RS1;
                        o_ctrl.alu_src_b = SRC_B_RS2;
                        o_ctrl.alu_op    = ALU_OP_SUB;
                        o_ctrl.pc_write  = i_br_taken;
                        o_ctrl.pc_src    = PC_SRC_ALUOUT;
                        o_ctrl.retire    = 1'b1;
                    end
                    OPCODE_JAL: begin
                        // Link value (PC, already +4) written as PC takes the target.
                        o_ctrl.reg_write = 1'b1;
                        o_ctrl.wb_sel    = WB_PC;
                        o_ctrl.pc_write  = 1'b1;
                        o_ctrl.pc_src    = PC_SRC_ALUOUT;
                        o_ctrl.retire    = 1'b1;
                    end
                    OPCODE_JALR: begin
                        o_ctrl.alu_src_a = SRC_A_RS1;
                        o_ctrl.alu_src_b = SRC_B_IMM;
                        o_ctrl.alu_op    = ALU_OP_ADD;
                        o_ctrl.reg_write = 1'b1;
                        o_ctrl.wb_sel    = WB_PC;
                        o_ctrl.pc_write  = 1'b1;
                        o_ctrl.pc_src    = PC_SRC_JALR;
                        o_ctrl.retire    = 1'b1;
                    end
                    OPCODE_LUI: begin
                        o_ctrl.reg_write = 1'b1;
                        o_ctrl.wb_sel    = WB_IMM;
                        o_ctrl.retire    = 1'b1;
                    end
                    OPCODE_AUIPC: begin
                        // ALUOUT already holds OLD_PC+IMM from DECODE.
                        o_ctrl.reg_write = 1'b1;
                        o_ctrl.wb_sel    = WB_ALUOUT;
                        o_ctrl.retire    = 1'b1;
                    end
                    default: begin
                        o_next_state = ST_FETCH;
                    end
                endcase
            end

            ST_MEM: begin
                if (i_opcode == OPCODE_LOAD) begin
                    o_ctrl.mem_read = 1'b1;
                    if (i_mem_ready) begin
                        o_next_state = ST_WB;
                    end
                end else if (i_opcode == OPCODE_STORE) begin
                    o_ctrl.mem_write = 1'b1;
                    if (i_mem_ready) begin
                        o_ctrl.retire = 1'b1;
                        o_next_state  = ST_FETCH;
                    end
                end else begin
                    o_next_state = ST_FETCH;
                end
            end

            ST_WB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.wb_sel    = (i_opcode == OPCODE_LOAD) ? WB_MDR : WB_ALUOUT;
                o_ctrl.retire    = 1'b1;
                o_next_state     = ST_FETCH;
            end

            ST_HALT: begin
                o_next_state = ST_HALT;
            end

            default: begin
                o_next_state = ST_FETCH;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core. Holds the state and sticky
// illegal-opcode registers; all datapath controls are decoded combinationally
// from the current state and opcode and forced to zero while rst is high.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter bit HALT_ON_SYSTEM = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] opcode,
    input  logic       br_taken,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       retire,
    output logic       illegal,
    output logic       halted
);

    state_t r_state;
    logic   r_illegal;
    state_t w_next_state;
    logic   w_set_illegal;
    ctrl_t  w_ctrl;
    ctrl_t  w_ctrl_gated;

    multicycle_ctrl_decode #(
        .HALT_ON_SYSTEM (HALT_ON_SYSTEM)
    ) u_decode (
        .i_state       (r_state),
        .i_opcode      (opcode),
        .i_br_taken    (br_taken),
        .i_mem_ready   (mem_ready),
        .o_ctrl        (w_ctrl),
        .o_next_state  (w_next_state),
        .o_set_illegal (w_set_illegal)
    );

    // State advance and sticky illegal flag; reset returns to FETCH at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Reset also masks the decoded FETCH word so no request escapes while
    // rst is held, including a handshake that was in flight.
    assign w_ctrl_gated = rst ? '0 : w_ctrl;

    assign mem_read  = w_ctrl_gated.mem_read;
    assign mem_write = w_ctrl_gated.mem_write;
    assign ir_write  = w_ctrl_gated.ir_write;
    assign pc_write  = w_ctrl_gated.pc_write;
    assign pc_src    = w_ctrl_gated.pc_src;
    assign alu_src_a = w_ctrl_gated.alu_src_a;
    assign alu_src_b = w_ctrl_gated.alu_src_b;
    assign alu_op    = w_ctrl_gated.alu_op;
    assign reg_write = w_ctrl_gated.reg_write;
    assign wb_sel    = w_ctrl_gated.wb_sel;
    assign retire    = w_ctrl_gated.retire;
    assign illegal   = r_illegal;
    assign halted    = !rst && (r_state == ST_HALT);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table of per-instruction latency and
// enable counts, randomized instruction stream against a phase-level reference,
// and hand-written reset / halt / JALR sequences.
module tb_multicycle_ctrl;

    localparam logic [4:0] LOAD   = 5'b00000;
    localparam logic [4:0] FENCE  = 5'b00011;
    localparam logic [4:0] OPIMM  = 5'b00100;
    localparam logic [4:0] AUIPC  = 5'b00101;
    localparam logic [4:0] STORE  = 5'b01000;
    localparam logic [4:0] OPR    = 5'b01100;
    localparam logic [4:0] LUI    = 5'b01101;
    localparam logic [4:0] BRANCH = 5'b11000;
    localparam logic [4:0] JALR   = 5'b11001;
    localparam logic [4:0] JAL    = 5'b11011;
    localparam logic [4:0] SYSTEM = 5'b11100;

    // Instruction phases seen by the reference model.
    localparam int PH_FW  = 0;  // fetch, memory not ready
    localparam int PH_FG  = 1;  // fetch, memory ready
    localparam int PH_DEC = 2;
    localparam int PH_EX  = 3;
    localparam int PH_MW  = 4;  // data access, memory not ready
    localparam int PH_MG  = 5;  // data access, memory ready
    localparam int PH_WB  = 6;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       retire;
        logic       halted;
    } cw_t;

    typedef struct {
        logic [4:0] op;
        logic       br;
        logic       mr;
        cw_t        exp;
    } step_t;

    typedef struct {
        logic [4:0] op;
        int         fw;
        int         mw;
        logic       br;
        int         cycles;
        int         reads;
        int         writes;
        int         regw;
        int         pcw;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] opcode;
    logic       br_taken;
    logic       mem_ready;
    logic       mem_read, mem_write, ir_write, pc_write, reg_write, retire;
    logic       illegal, halted;
    logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, wb_sel;
    cw_t        act;

    int tests = 0;
    int fails = 0;
    step_t q[$];

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .br_taken  (br_taken),
        .mem_ready (mem_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .reg_write (reg_write),
        .wb_sel    (wb_sel),
        .retire    (retire),
        .illegal   (illegal),
        .halted    (halted)
    );

    assign act = {mem_read, mem_write, ir_write, pc_write, pc_src, alu_src_a,
                  alu_src_b, alu_op, reg_write, wb_sel, retire, halted};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Expected control word for one cycle of an instruction in a given phase.
    function automatic cw_t expect_word(input int ph, input logic [4:0] op, input logic br);
        cw_t w;
        w = '0;
        case (ph)
            PH_FW: begin
                w.mem_read = 1'b1; w.src_b = 2'd1;
            end
            PH_FG: begin
                w.mem_read = 1'b1; w.src_b = 2'd1; w.ir_write = 1'b1; w.pc_write = 1'b1;
            end
            PH_DEC: begin
                w.src_a = 2'd1; w.src_b = 2'd2; w.retire = (op == FENCE);
            end
            PH_EX: begin
                if (op == OPR) begin
                    w.src_a = 2'd2; w.src_b = 2'd0; w.alu_op = 2'd2;
                end else if (op == OPIMM) begin
                    w.src_a = 2'd2; w.src_b = 2'd2; w.alu_op = 2'd3;
                end else if (op == LOAD || op == STORE) begin
                    w.src_a = 2'd2; w.src_b = 2'd2;
                end else if (op == BRANCH) begin
                    w.src_a = 2'd2; w.alu_op = 2'd1; w.pc_write = br; w.pc_src = 2'd1;
                    w.retire = 1'b1;
                end else if (op == JAL) begin
                    w.reg_write = 1'b1; w.wb_sel = 2'd2; w.pc_write = 1'b1; w.pc_src = 2'd1;
                    w.retire = 1'b1;
                end else if (op == JALR) begin
                    w.src_a = 2'd2; w.src_b = 2'd2; w.reg_write = 1'b1; w.wb_sel = 2'd2;
                    w.pc_write = 1'b1; w.pc_src = 2'd2; w.retire = 1'b1;
                end else if (op == LUI) begin
                    w.reg_write = 1'b1; w.wb_sel = 2'd3; w.retire = 1'b1;
                end else if (op == AUIPC) begin
                    w.reg_write = 1'b1; w.retire = 1'b1;
                end
            end
            PH_MW, PH_MG: begin
                w.mem_read  = (op == LOAD);
                w.mem_write = (op == STORE);
                w.retire    = (ph == PH_MG) && (op == STORE);
            end
            PH_WB: begin
                w.reg_write = 1'b1; w.wb_sel = (op == LOAD) ? 2'd1 : 2'd0; w.retire = 1'b1;
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    function automatic logic rbit();
        return ($urandom_range(0, 1) == 1);
    endfunction

    task automatic push(input int ph, input logic [4:0] op, input logic mr);
        step_t s;
        s.op  = op;
        s.br  = rbit();
        s.mr  = mr;
        s.exp = expect_word(ph, op, s.br);
        q.push_back(s);
    endtask

    // Lay out one instruction as a list of cycles with chosen wait counts.
    task automatic build(input logic [4:0] op, input int fw, input int mw);
        for (int i = 0; i < fw; i++) push(PH_FW, op, 1'b0);
        push(PH_FG, op, 1'b1);
        push(PH_DEC, op, rbit());
        if (op == FENCE) return;
        push(PH_EX, op, rbit());
        if (op == LOAD || op == STORE) begin
            for (int i = 0; i < mw; i++) push(PH_MW, op, 1'b0);
            push(PH_MG, op, 1'b1);
        end
        if (op == LOAD || op == OPR || op == OPIMM) push(PH_WB, op, rbit());
    endtask

    // Drive each queued cycle after the rising edge, compare mid-cycle.
    task automatic run_queue(input string tag);
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            opcode    = s.op;
            br_taken  = s.br;
            mem_ready = s.mr;
            @(negedge clk);
            chk(tag, 32'(act), 32'(s.exp));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic br, input logic mr);
        opcode = op; br_taken = br; mem_ready = mr;
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        chk("reset_clears_illegal", 32'(illegal), 32'd0);
        chk("reset_clears_halted", 32'(halted), 32'd0);
        advance();
        rst = 1'b0;
    endtask

    vec_t vt[11];
    logic [4:0] legal[10];

    initial begin
        cw_t w;
        int  c, nrd, nwr, nrw, npw;
        bit  done;

        vt[0]  = '{OPR,    0, 0, 1'b0,  4, 1, 0, 1, 1};
        vt[1]  = '{LOAD,   3, 2, 1'b0, 10, 7, 0, 1, 1};
        vt[2]  = '{STORE,  1, 1, 1'b0,  6, 2, 2, 0, 1};
        vt[3]  = '{BRANCH, 0, 0, 1'b1,  3, 1, 0, 0, 2};
        vt[4]  = '{BRANCH, 0, 0, 1'b0,  3, 1, 0, 0, 1};
        vt[5]  = '{JAL,    2, 0, 1'b0,  5, 3, 0, 1, 2};
        vt[6]  = '{JALR,   0, 0, 1'b0,  3, 1, 0, 1, 2};
        vt[7]  = '{LUI,    0, 0, 1'b1,  3, 1, 0, 1, 1};
        vt[8]  = '{AUIPC,  1, 0, 1'b0,  4, 2, 0, 1, 1};
        vt[9]  = '{FENCE,  0, 0, 1'b0,  2, 1, 0, 0, 1};
        vt[10] = '{OPIMM,  0, 0, 1'b1,  4, 1, 0, 1, 1};
        legal  = '{LOAD, STORE, OPR, OPIMM, BRANCH, JAL, JALR, LUI, AUIPC, FENCE};

        // Reset held: everything quiet even with memory signalling ready.
        rst = 1'b1; opcode = LOAD; br_taken = 1'b1; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'(act), 32'd0);
        chk("reset_illegal", 32'(illegal), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table: latency and per-instruction enable counts.
        for (int v = 0; v < 11; v++) begin
            c = 0; nrd = 0; nwr = 0; nrw = 0; npw = 0; done = 1'b0;
            while (!done && c < 40) begin
                opcode   = vt[v].op;
                br_taken = vt[v].br;
                if (c < vt[v].fw) mem_ready = 1'b0;
                else if (c == vt[v].fw) mem_ready = 1'b1;
                else if (c >= vt[v].fw + 3 && c < vt[v].fw + 3 + vt[v].mw) mem_ready = 1'b0;
                else mem_ready = 1'b1;
                @(negedge clk);
                nrd += int'(mem_read);
                nwr += int'(mem_write);
                nrw += int'(reg_write);
                npw += int'(pc_write);
                c++;
                done = retire;
                advance();
            end
            chk($sformatf("vec%0d_cycles", v), 32'(c), 32'(vt[v].cycles));
            chk($sformatf("vec%0d_mem_read_cycles", v), 32'(nrd), 32'(vt[v].reads));
            chk($sformatf("vec%0d_mem_write_cycles", v), 32'(nwr), 32'(vt[v].writes));
            chk($sformatf("vec%0d_reg_write_cycles", v), 32'(nrw), 32'(vt[v].regw));
            chk($sformatf("vec%0d_pc_write_cycles", v), 32'(npw), 32'(vt[v].pcw));
        end

        // Randomized instruction stream against the phase model.
        for (int n = 0; n < 150; n++) begin
            build(legal[$urandom_range(0, 9)], $urandom_range(0, 3), $urandom_range(0, 3));
            run_queue("random_word");
        end

        // JALR: full EXEC word in a single cycle.
        drive(JALR, 1'b0, 1'b1); advance();
        drive(JALR, 1'b0, 1'b0); advance();
        drive(JALR, 1'b0, 1'b0);
        w = '0;
        w.pc_write = 1'b1; w.pc_src = 2'b10; w.src_a = 2'b10; w.src_b = 2'b10;
        w.reg_write = 1'b1; w.wb_sel = 2'b10; w.retire = 1'b1;
        chk("jalr_exec_word", 32'(act), 32'(w));
        advance();

        // Reset in the middle of a LOAD data access.
        drive(LOAD, 1'b0, 1'b1); advance();
        drive(LOAD, 1'b0, 1'b1); advance();
        drive(LOAD, 1'b0, 1'b1); advance();
        drive(LOAD, 1'b0, 1'b0);
        chk("midmem_read_active", 32'(mem_read), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midmem_reset_gates", 32'(act), 32'd0);
        chk("midmem_reset_illegal", 32'(illegal), 32'd0);
        advance();
        rst = 1'b0;
        drive(LOAD, 1'b0, 1'b0);
        chk("post_reset_fetch", 32'(act), 32'(expect_word(PH_FW, LOAD, 1'b0)));
        advance();
        drive(LOAD, 1'b0, 1'b0);
        chk("post_reset_fetch_wait", 32'(act), 32'(expect_word(PH_FW, LOAD, 1'b0)));
        advance();
        build(LOAD, 0, 1);
        run_queue("post_reset_load");

        // SYSTEM halts (default HALT_ON_SYSTEM) without flagging illegal.
        drive(SYSTEM, 1'b0, 1'b1); advance();
        drive(SYSTEM, 1'b0, 1'b0);
        chk("system_decode", 32'(act), 32'(expect_word(PH_DEC, SYSTEM, 1'b0)));
        advance();
        w = '0;
        w.halted = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(SYSTEM, rbit(), i[0]);
            chk("system_halt_word", 32'(act), 32'(w));
            chk("system_no_illegal", 32'(illegal), 32'd0);
            advance();
        end
        pulse_reset();

        // Unknown opcode: DECODE, then HALT with sticky illegal.
        drive(5'b11111, 1'b0, 1'b1); advance();
        drive(5'b11111, 1'b0, 1'b0);
        chk("illegal_decode", 32'(act), 32'(expect_word(PH_DEC, 5'b11111, 1'b0)));
        chk("illegal_not_yet", 32'(illegal), 32'd0);
        advance();
        for (int i = 0; i < 6; i++) begin
            drive(legal[i], 1'b1, i[0]);
            chk("illegal_halt_word", 32'(act), 32'(w));
            chk("illegal_sticky", 32'(illegal), 32'd1);
            advance();
        end
        pulse_reset();
        build(OPR, 1, 0);
        run_queue("recover_op");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Overall time bound so the run always ends.
    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: got timeout required completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multi-cycle RV32I core. It sequences one shared ALU, the IR/PC registers, the register file and a single ready-handshaked memory port across FETCH/DECODE/EXEC/MEM/WB. It drives the 2-bit ALU operation class consumed by the ALU control decoder: 00 ADD, 01 SUB, 10 R-type funct, 11 I-type funct. It sits between the IR opcode field and all datapath enables and selects.

Parameters:
HALT_ON_SYSTEM, 1, 1: SYSTEM opcode enters HALT; 0: SYSTEM retires as a NOP.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
opcode  in  5  IR[6:2]; stable from DECODE until the instruction retires
br_taken  in  1  branch-comparator result for current rs1/rs2/funct3
mem_ready  in  1  memory completes current request this cycle
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  latch IR and OLD_PC (= current PC)
pc_write  out  1  update PC
pc_src  out  2  00 ALU result, 01 ALUOUT reg, 10 ALU result & ~1
alu_src_a  out  2  00 PC, 01 OLD_PC, 10 RS1
alu_src_b  out  2  00 RS2, 01 const 4, 10 IMM
alu_op  out  2  ALU operation class (encoding in Overview)
reg_write  out  1  register-file write enable
wb_sel  out  2  00 ALUOUT, 01 MDR, 10 PC, 11 IMM
retire  out  1  one-cycle pulse on last cycle of each instruction
illegal  out  1  sticky; unknown opcode decoded
halted  out  1  FSM in HALT

Behaviour:
- Reset (async, any state, mid-handshake included): state FETCH; illegal=0; halted=0. While rst is high, every enable, select, alu_op and retire is 0. The first cycle after release is FETCH.
- Outputs are combinational from state and opcode; only state and illegal are registered.
- FETCH: mem_read=1, src_a=PC, src_b=4, alu_op=00. Stay while !mem_ready. On mem_ready: ir_write=1, pc_write=1, pc_src=00 (PC <= PC+4), then DECODE.
- DECODE: src_a=OLD_PC, src_b=IMM, alu_op=00 (ALUOUT <= branch/AUIPC target).
  - FENCE(00011): retire, then FETCH.
  - SYSTEM(11100): HALT if HALT_ON_SYSTEM, else retire and FETCH.
  - Unknown opcode: illegal<=1, then HALT.
  - Otherwise EXEC.
- EXEC:
  - OP(01100): RS1, RS2, alu_op=10; then WB.
  - OP_IMM(00100): RS1, IMM, alu_op=11; then WB.
  - LOAD(00000)/STORE(01000): RS1, IMM, alu_op=00; then MEM.
  - BRANCH(11000): RS1, RS2, alu_op=01; pc_write=br_taken, pc_src=01; retire; then FETCH.
  - JAL(11011): reg_write, wb_sel=10 (old PC+4 written on the same edge the PC updates), pc_write, pc_src=01; retire; FETCH.
  - JALR(11001): RS1, IMM, alu_op=00; reg_write, wb_sel=10, pc_write, pc_src=10; retire; FETCH.
  - LUI(01101): reg_write, wb_sel=11; retire; FETCH.
  - AUIPC(00101): reg_write, wb_sel=00; retire; FETCH.
- MEM: LOAD holds mem_read=1 and STORE holds mem_write=1 until mem_ready; the address comes from ALUOUT. On mem_ready, LOAD goes to WB (datapath latches MDR) and STORE retires to FETCH.
- WB: reg_write=1, wb_sel=01 for LOAD, otherwise 00; retire; FETCH.
- HALT: absorbing until rst. All enables are 0, halted=1, and illegal keeps its value.
- Invariants:
  - mem_read and mem_write are never both 1.
  - mem_ready is ignored when no request is active.
  - At most one retire per instruction.
  - rd=x0 suppression belongs to the register file.
- Zero-wait latency in cycles: FENCE 2, BRANCH/JAL/JALR/LUI/AUIPC 3, OP/OP_IMM/STORE 4, LOAD 5. Each memory wait cycle adds 1.

Decomposition:
- defines.v gains:
  - opcode constants (OPCODE_*)
  - state encoding (FETCH, DECODE, EXEC, MEM, WB, HALT; 3 bits)
  - alu_op class codes
  - pc_src, alu_src_a, alu_src_b and wb_sel encodings
- One natural sub-module: multicycle_ctrl_decode, purely combinational. It maps (state, opcode, br_taken, mem_ready) to the control word plus next state. multicycle_ctrl keeps only the state/illegal registers and the reset gating.

Test Plan:
- rst pulse mid-MEM of a LOAD with mem_read=1 -> same cycle all enables 0. Two cycles after release: mem_read=1 in FETCH, illegal=0.
- OP (01100), mem_ready tied 1 -> FETCH, DECODE, EXEC (alu_op=10, srcs 10/00), WB (reg_write=1, wb_sel=00). retire in cycle 4 only.
- LOAD with mem_ready low 3 cycles in FETCH and 2 in MEM -> total 10 cycles; mem_read held through waits; WB wb_sel=01.
- BRANCH with br_taken=1, then br_taken=0 -> EXEC pc_write=1, pc_src=01 vs pc_write=0; 3 cycles each.
- JALR -> EXEC shows reg_write=1, wb_sel=10, pc_write=1, pc_src=10, alu_src_a=10, alu_src_b=10 in one cycle.
- Opcode 11111 -> DECODE then HALT, illegal=1, halted=1. mem_ready toggling causes no enables; state is left only by rst.
